// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial N-bit subtractor (d = a - b mod 2^N), LSB first.
// A load edge is followed by N shift edges, then a single DONE cycle.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub4 #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bo
`ifdef SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_res;
  logic [CW-1:0] r_cnt;
  logic          r_br;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_d;
  logic          r_bo;
`ifdef SUB_OVF_EN
  // Sign bits of the operands as loaded; the operand registers shift them away.
  logic          r_a_msb;
  logic          r_b_msb;
  logic          r_ovf;
`endif

  logic          w_diff;
  logic          w_br_next;
  logic [N-1:0]  w_res_next;
  logic          w_last;

  // One full-subtractor slice on the current LSBs.
  assign w_diff     = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_next = {w_diff, r_res[N-1:1]};
  assign w_last     = (r_cnt == CNT_LAST);

  // Control FSM, datapath shifting and registered outputs in one process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= {N{1'b0}};
      r_b     <= {N{1'b0}};
      r_res   <= {N{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_br    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= {N{1'b0}};
      r_bo    <= 1'b0;
`ifdef SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= {N{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_br    <= 1'b0;
            r_busy  <= 1'b1;
`ifdef SUB_OVF_EN
            r_a_msb <= a[N-1];
            r_b_msb <= b[N-1];
`endif
            r_state <= S_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a   <= {1'b0, r_a[N-1:1]};
          r_b   <= {1'b0, r_b[N-1:1]};
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CNT_ONE;
          if (w_last) begin
            // Last bit: publish the result; d/bo change only here.
            r_d     <= w_res_next;
            r_bo    <= w_br_next;
`ifdef SUB_OVF_EN
            r_ovf   <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_DONE: begin
          // start is ignored here; always return to IDLE.
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d    = r_d;
  assign bo   = r_bo;
`ifdef SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule
